valu_wb_collector: RTL and testbench
====================================

Name: valu_wb_collector

Overview:
- Consumer side of the vector ALU result interface.
- Accepts the register-writeback stream (out_valid/out_ready) and the SIMT-stack stream (out2simt_valid/out2simt_ready) produced by the vector ALU.
- Buffers the writeback stream in a DEPTH-entry FIFO and drives the register-file write port.
- Buffers the SIMT stream in a one-entry register and forwards it to the SIMT stack.
- Entries that do not write a register are discarded inside the block.

Parameters:
- SOFT_THREAD, 4, lanes per result; data width is SOFT_THREAD*`XLEN.
- DEPTH, 2, writeback FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- alu_valid_i  in  1  writeback result valid; drive from ALU out_valid_o.
- alu_ready_o  out  1  writeback ready; drive to ALU out_ready_i.
- alu_wb_data_i  in  SOFT_THREAD*`XLEN  per-lane result.
- alu_wb_mask_i  in  SOFT_THREAD  lane write mask.
- alu_wvd_i  in  1  1 = write vector register.
- alu_reg_idxw_i  in  `REGIDX_WIDTH+`REGEXT_WIDTH  destination register.
- alu_warp_id_i  in  `DEPTH_WARP  warp id.
- simt_valid_i  in  1  from ALU out2simt_valid_o.
- simt_ready_o  out  1  to ALU out2simt_ready_i.
- simt_if_mask_i  in  SOFT_THREAD  branch taken mask.
- simt_wid_i  in  `DEPTH_WARP  warp id of the branch.
- rf_wr_valid_o  out  1  register-file write request.
- rf_wr_ready_i  in  1  register-file accepts the write.
- rf_wr_data_o  out  SOFT_THREAD*`XLEN  write data.
- rf_wr_mask_o  out  SOFT_THREAD  write lane mask.
- rf_wr_idx_o  out  `REGIDX_WIDTH+`REGEXT_WIDTH  write register.
- rf_wr_wid_o  out  `DEPTH_WARP  write warp.
- stk_valid_o  out  1  SIMT-stack update valid.
- stk_ready_i  in  1  SIMT stack accepts the update.
- stk_if_mask_o  out  SOFT_THREAD  forwarded if_mask.
- stk_wid_o  out  `DEPTH_WARP  forwarded warp id.
- count_o  out  CW  current FIFO occupancy.

Behaviour:
- Reset:
  - rst=1 at a clock edge clears the FIFO read pointer, write pointer and count, and clears the SIMT register valid.
  - Outputs after reset: rf_wr_valid_o=0, stk_valid_o=0, count_o=0, alu_ready_o=1, simt_ready_o=1.
  - FIFO data and SIMT data are not reset; they are don't-care while their valid is 0.
  - Reset asserted mid-transfer discards all buffered entries; nothing is written after reset.
- Writeback FIFO:
  - Push condition: alu_valid_i && alu_ready_o.
  - alu_ready_o = (count_o != DEPTH). It is registered-derived and has no combinational path from rf_wr_ready_i, so a full FIFO refuses a push even when it pops in the same cycle.
  - Latency: an entry pushed at edge N is visible at the head from cycle N+1.
  - Head with wvd=1: rf_wr_valid_o=1 and rf_wr_* show the head fields. The entry pops when rf_wr_ready_i=1.
  - Head with wvd=0: rf_wr_valid_o=0. The entry is popped unconditionally in that cycle, costing one cycle per discarded entry.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - count_o reflects state after the last edge.
  - Order is strictly FIFO.
  - While rf_wr_valid_o=1 and rf_wr_ready_i=0, all rf_wr_* outputs hold stable.
- SIMT register:
  - One entry, with a valid bit.
  - simt_ready_o = !stk_valid_o || stk_ready_i; a combinational pass-through from stk_ready_i is allowed.
  - On simt_valid_i && simt_ready_o, capture if_mask and wid and set valid.
  - Else on stk_ready_i, clear valid.
  - Accept and drain in the same cycle: the new value replaces the old one and valid stays 1.
  - Latency is 1 cycle.
  - stk_* outputs hold while stalled.
- The two channels are fully independent; neither stalls the other.

Test Plan:
- Reset, then idle: count_o=0, rf_wr_valid_o=0, stk_valid_o=0, alu_ready_o=1, simt_ready_o=1.
- Single write, wvd=1, data=0x4433221100FFEEDD_8877665544332211, mask=4'b1010, idx=5, wid=2, rf_wr_ready_i=1:
  - Cycle after push: rf_wr_valid_o=1 with the same fields, count_o=1.
  - Next cycle: count_o=0.
- Fill and stall, rf_wr_ready_i=0:
  - Push 3 entries back to back with DEPTH=2.
  - Required: alu_ready_o=0 after 2 pushes, third push held, count_o=2.
  - Release ready: entries appear in order A, B, C with no drops or duplicates.
- Discard: push wvd=0 then wvd=1 (idx=7) with rf_wr_ready_i=1.
  - Required: no write for the first entry; the idx=7 write appears 2 cycles after the first push.
- SIMT channel: simt if_mask=4'b0110, wid=1 with stk_ready_i=0 for 3 cycles.
  - Required: stk_valid_o=1, outputs stable, simt_ready_o=0.
  - Then stk_ready_i=1 together with a new simt_valid_i (mask 4'b0001): the value is replaced and valid stays 1.
- Reset mid-operation: with the FIFO holding 2 entries, assert rst for 1 cycle.
  - Required: count_o=0 and rf_wr_valid_o=0 next cycle, and no stale entry is ever emitted.

Source files
------------

// File: rtl/valu_wb_collector_if.sv
// Result-side bus of the vector ALU: writeback stream, SIMT-stack stream and the
// register-file / SIMT-stack ports fed by the collector.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

interface valu_wb_collector_if #(
  parameter int SOFT_THREAD = 4,
  parameter int DEPTH       = 2,
  parameter int CW          = $clog2(DEPTH + 1)
);
  logic                                     alu_valid_i;
  logic                                     alu_ready_o;
  logic [SOFT_THREAD*`XLEN-1:0]             alu_wb_data_i;
  logic [SOFT_THREAD-1:0]                   alu_wb_mask_i;
  logic                                     alu_wvd_i;
  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]   alu_reg_idxw_i;
  logic [`DEPTH_WARP-1:0]                   alu_warp_id_i;

  logic                                     simt_valid_i;
  logic                                     simt_ready_o;
  logic [SOFT_THREAD-1:0]                   simt_if_mask_i;
  logic [`DEPTH_WARP-1:0]                   simt_wid_i;

  logic                                     rf_wr_valid_o;
  logic                                     rf_wr_ready_i;
  logic [SOFT_THREAD*`XLEN-1:0]             rf_wr_data_o;
  logic [SOFT_THREAD-1:0]                   rf_wr_mask_o;
  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]   rf_wr_idx_o;
  logic [`DEPTH_WARP-1:0]                   rf_wr_wid_o;

  logic                                     stk_valid_o;
  logic                                     stk_ready_i;
  logic [SOFT_THREAD-1:0]                   stk_if_mask_o;
  logic [`DEPTH_WARP-1:0]                   stk_wid_o;

  logic [CW-1:0]                            count_o;

  modport master (
    output alu_valid_i, alu_wb_data_i, alu_wb_mask_i, alu_wvd_i, alu_reg_idxw_i, alu_warp_id_i,
    output simt_valid_i, simt_if_mask_i, simt_wid_i, rf_wr_ready_i, stk_ready_i,
    input  alu_ready_o, simt_ready_o, rf_wr_valid_o, rf_wr_data_o, rf_wr_mask_o,
    input  rf_wr_idx_o, rf_wr_wid_o, stk_valid_o, stk_if_mask_o, stk_wid_o, count_o
  );

  modport slave (
    input  alu_valid_i, alu_wb_data_i, alu_wb_mask_i, alu_wvd_i, alu_reg_idxw_i, alu_warp_id_i,
    input  simt_valid_i, simt_if_mask_i, simt_wid_i, rf_wr_ready_i, stk_ready_i,
    output alu_ready_o, simt_ready_o, rf_wr_valid_o, rf_wr_data_o, rf_wr_mask_o,
    output rf_wr_idx_o, rf_wr_wid_o, stk_valid_o, stk_if_mask_o, stk_wid_o, count_o
  );
endinterface

// File: rtl/valu_wb_collector.sv
// Vector ALU result collector: DEPTH-entry writeback FIFO in front of the register
// file write port, plus a one-entry skid register in front of the SIMT stack.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module valu_wb_collector #(
  parameter int SOFT_THREAD = 4,
  parameter int DEPTH       = 2,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  valu_wb_collector_if.slave bus
);
  localparam int DW = SOFT_THREAD * `XLEN;
  localparam int IW = `REGIDX_WIDTH + `REGEXT_WIDTH;
  localparam int WW = `DEPTH_WARP;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]          r_data [DEPTH];
  logic [SOFT_THREAD-1:0] r_mask [DEPTH];
  logic                   r_wvd  [DEPTH];
  logic [IW-1:0]          r_idx  [DEPTH];
  logic [WW-1:0]          r_wid  [DEPTH];

  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;

  logic                   r_stk_vld;
  logic [SOFT_THREAD-1:0] r_stk_mask;
  logic [WW-1:0]          r_stk_wid;

  logic w_head_vld;
  logic w_head_wvd;
  logic w_push;
  logic w_pop;
  logic w_alu_ready;
  logic w_simt_ready;
  logic w_simt_acc;

  // Ready depends only on registered occupancy, so a full FIFO never accepts a push
  // in the cycle it pops; this keeps rf_wr_ready_i out of the ALU's ready path.
  assign w_alu_ready = (r_count != CW'(DEPTH));
  assign w_head_vld  = (r_count != '0);
  assign w_head_wvd  = r_wvd[r_rd_ptr];
  assign w_push      = bus.alu_valid_i && w_alu_ready;
  // Non-writing entries drain without waiting for the register file.
  assign w_pop       = w_head_vld && (!w_head_wvd || bus.rf_wr_ready_i);

  assign bus.alu_ready_o   = w_alu_ready;
  assign bus.rf_wr_valid_o = w_head_vld && w_head_wvd;
  assign bus.rf_wr_data_o  = r_data[r_rd_ptr];
  assign bus.rf_wr_mask_o  = r_mask[r_rd_ptr];
  assign bus.rf_wr_idx_o   = r_idx[r_rd_ptr];
  assign bus.rf_wr_wid_o   = r_wid[r_rd_ptr];
  assign bus.count_o       = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= bus.alu_wb_data_i;
      r_mask[r_wr_ptr] <= bus.alu_wb_mask_i;
      r_wvd[r_wr_ptr]  <= bus.alu_wvd_i;
      r_idx[r_wr_ptr]  <= bus.alu_reg_idxw_i;
      r_wid[r_wr_ptr]  <= bus.alu_warp_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_simt_ready = !r_stk_vld || bus.stk_ready_i;
  assign w_simt_acc   = bus.simt_valid_i && w_simt_ready;

  assign bus.simt_ready_o  = w_simt_ready;
  assign bus.stk_valid_o   = r_stk_vld;
  assign bus.stk_if_mask_o = r_stk_mask;
  assign bus.stk_wid_o     = r_stk_wid;

  always_ff @(posedge clk) begin
    if (w_simt_acc) begin
      r_stk_mask <= bus.simt_if_mask_i;
      r_stk_wid  <= bus.simt_wid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stk_vld <= 1'b0;
    end else if (w_simt_acc) begin
      r_stk_vld <= 1'b1;
    end else if (bus.stk_ready_i) begin
      r_stk_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_valu_wb_collector.sv
// Randomized and directed bench for valu_wb_collector against a queue-based model.
module tb_valu_wb_collector;
  localparam int DEPTH = 2;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   m;
    logic         wvd;
    logic [7:0]   idx;
    logic [2:0]   wid;
  } ent_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ent_t       q[$];
  logic       s_vld;
  logic [3:0] s_mask;
  logic [2:0] s_wid;
  logic       last_pushed;
  logic [7:0] wr_log[$];

  valu_wb_collector_if #(.SOFT_THREAD(4), .DEPTH(DEPTH)) bus ();

  valu_wb_collector #(.SOFT_THREAD(4), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare every output to the model at the falling edge, then advance the model.
  task automatic tick();
    logic exp_rdy;
    logic exp_wv;
    logic do_pop;
    ent_t e;
    @(negedge clk);
    exp_rdy = (q.size() != DEPTH);
    exp_wv  = (q.size() > 0) && q[0].wvd;
    check_eq("count", bus.count_o, q.size());
    check_eq("alu_ready", bus.alu_ready_o, exp_rdy);
    check_eq("rf_valid", bus.rf_wr_valid_o, exp_wv);
    if (exp_wv) begin
      check_eq("rf_data", bus.rf_wr_data_o, q[0].d);
      check_eq("rf_mask", bus.rf_wr_mask_o, q[0].m);
      check_eq("rf_idx", bus.rf_wr_idx_o, q[0].idx);
      check_eq("rf_wid", bus.rf_wr_wid_o, q[0].wid);
    end
    check_eq("stk_valid", bus.stk_valid_o, s_vld);
    check_eq("simt_ready", bus.simt_ready_o, !s_vld || bus.stk_ready_i);
    if (s_vld) begin
      check_eq("stk_mask", bus.stk_if_mask_o, s_mask);
      check_eq("stk_wid", bus.stk_wid_o, s_wid);
    end
    if (bus.rf_wr_valid_o && bus.rf_wr_ready_i) wr_log.push_back(bus.rf_wr_idx_o);

    last_pushed = 1'b0;
    if (rst) begin
      q.delete();
      s_vld = 1'b0;
    end else begin
      do_pop = (q.size() > 0) && (!q[0].wvd || bus.rf_wr_ready_i);
      if (do_pop) void'(q.pop_front());
      if (bus.alu_valid_i && exp_rdy) begin
        e.d = bus.alu_wb_data_i; e.m = bus.alu_wb_mask_i; e.wvd = bus.alu_wvd_i;
        e.idx = bus.alu_reg_idxw_i; e.wid = bus.alu_warp_id_i;
        q.push_back(e);
        last_pushed = 1'b1;
      end
      if (bus.simt_valid_i && (!s_vld || bus.stk_ready_i)) begin
        s_vld = 1'b1; s_mask = bus.simt_if_mask_i; s_wid = bus.simt_wid_i;
      end else if (bus.stk_ready_i) begin
        s_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic wvd, input logic [7:0] idx,
                         input logic [127:0] d, input logic [3:0] m, input logic [2:0] wid);
    bus.alu_valid_i = v; bus.alu_wvd_i = wvd; bus.alu_reg_idxw_i = idx;
    bus.alu_wb_data_i = d; bus.alu_wb_mask_i = m; bus.alu_warp_id_i = wid;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    s_vld = 1'b0; s_mask = '0; s_wid = '0;
    rst = 1'b1;
    set_alu(1'b0, 1'b0, 8'd0, '0, 4'd0, 3'd0);
    bus.simt_valid_i = 1'b0; bus.simt_if_mask_i = '0; bus.simt_wid_i = '0;
    bus.rf_wr_ready_i = 1'b0; bus.stk_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("idle_count", bus.count_o, 0);
    check_eq("idle_rfv", bus.rf_wr_valid_o, 0);
    check_eq("idle_stkv", bus.stk_valid_o, 0);
    check_eq("idle_ardy", bus.alu_ready_o, 1);
    check_eq("idle_srdy", bus.simt_ready_o, 1);

    // Single write
    bus.rf_wr_ready_i = 1'b1;
    set_alu(1'b1, 1'b1, 8'd5, 128'h4433221100FFEEDD_8877665544332211, 4'b1010, 3'd2);
    tick();
    bus.alu_valid_i = 1'b0;
    check_eq("sw_valid", bus.rf_wr_valid_o, 1);
    check_eq("sw_data", bus.rf_wr_data_o, 128'h4433221100FFEEDD_8877665544332211);
    check_eq("sw_mask", bus.rf_wr_mask_o, 4'b1010);
    check_eq("sw_idx", bus.rf_wr_idx_o, 8'd5);
    check_eq("sw_wid", bus.rf_wr_wid_o, 3'd2);
    check_eq("sw_count1", bus.count_o, 1);
    tick();
    check_eq("sw_count0", bus.count_o, 0);

    // Fill and stall
    bus.rf_wr_ready_i = 1'b0;
    set_alu(1'b1, 1'b1, 8'd1, 128'hA, 4'hF, 3'd1); tick();
    set_alu(1'b1, 1'b1, 8'd2, 128'hB, 4'hF, 3'd1); tick();
    set_alu(1'b1, 1'b1, 8'd3, 128'hC, 4'hF, 3'd1); tick();
    check_eq("fill_ardy", bus.alu_ready_o, 0);
    check_eq("fill_count", bus.count_o, 2);
    tick();
    check_eq("fill_hold_count", bus.count_o, 2);
    check_eq("fill_hold_idx", bus.rf_wr_idx_o, 8'd1);
    wr_log.delete();
    bus.rf_wr_ready_i = 1'b1;
    for (int i = 0; i < 10 && !last_pushed; i++) tick();
    check_eq("fill_c_pushed", last_pushed, 1);
    bus.alu_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("fill_nwr", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check_eq("fill_ordA", wr_log[0], 8'd1);
      check_eq("fill_ordB", wr_log[1], 8'd2);
      check_eq("fill_ordC", wr_log[2], 8'd3);
    end

    // Discard
    set_alu(1'b1, 1'b0, 8'd6, 128'h6, 4'hF, 3'd0); tick();
    check_eq("disc_nowr", bus.rf_wr_valid_o, 0);
    set_alu(1'b1, 1'b1, 8'd7, 128'h7, 4'hF, 3'd0); tick();
    bus.alu_valid_i = 1'b0;
    check_eq("disc_wr", bus.rf_wr_valid_o, 1);
    check_eq("disc_idx", bus.rf_wr_idx_o, 8'd7);
    tick(); tick();

    // SIMT channel
    bus.stk_ready_i = 1'b0;
    bus.simt_valid_i = 1'b1; bus.simt_if_mask_i = 4'b0110; bus.simt_wid_i = 3'd1;
    tick();
    bus.simt_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("simt_hold_v", bus.stk_valid_o, 1);
      check_eq("simt_hold_m", bus.stk_if_mask_o, 4'b0110);
      check_eq("simt_hold_w", bus.stk_wid_o, 3'd1);
      check_eq("simt_hold_r", bus.simt_ready_o, 0);
      tick();
    end
    bus.stk_ready_i = 1'b1;
    bus.simt_valid_i = 1'b1; bus.simt_if_mask_i = 4'b0001; bus.simt_wid_i = 3'd4;
    tick();
    bus.simt_valid_i = 1'b0;
    check_eq("simt_repl_v", bus.stk_valid_o, 1);
    check_eq("simt_repl_m", bus.stk_if_mask_o, 4'b0001);
    tick();
    check_eq("simt_drain", bus.stk_valid_o, 0);

    // Reset mid-operation
    bus.rf_wr_ready_i = 1'b0;
    set_alu(1'b1, 1'b1, 8'd9, 128'h9, 4'hF, 3'd3); tick();
    set_alu(1'b1, 1'b1, 8'd10, 128'h10, 4'hF, 3'd3); tick();
    bus.alu_valid_i = 1'b0;
    check_eq("mrst_count2", bus.count_o, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("mrst_count0", bus.count_o, 0);
    check_eq("mrst_rfv", bus.rf_wr_valid_o, 0);
    bus.rf_wr_ready_i = 1'b1;
    wr_log.delete();
    for (int i = 0; i < 4; i++) tick();
    check_eq("mrst_nostale", wr_log.size(), 0);

    // Random traffic on both channels
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_alu($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 3'($urandom));
      bus.rf_wr_ready_i = ($urandom_range(0, 2) != 0);
      bus.simt_valid_i = ($urandom_range(0, 1) != 0);
      bus.simt_if_mask_i = 4'($urandom);
      bus.simt_wid_i = 3'($urandom);
      bus.stk_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0;
    bus.alu_valid_i = 1'b0; bus.simt_valid_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
